// File: rtl/router_pkt_reg_if.sv
// Bus between the router FSM / input port and the router datapath register stage.
// The source and FSM side drives through master; router_pkt_reg takes slave.
interface router_pkt_reg_if #(
  parameter int DATA_WIDTH = 8
);
  // pkt_valid qualifies data_in for every byte of a packet and drops on the
  // parity-byte cycle. There is no ready: the FSM state flags below decide
  // whether the byte is taken, and fifo_full stalls the write into the FIFO.
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  full_state;
  logic                  laf_state;
  logic                  rst_int_reg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  low_pkt_valid;
  logic                  parity_done;
  logic                  err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
    input  dout, low_pkt_valid, parity_done, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg,
    output dout, low_pkt_valid, parity_done, err
  );
endinterface

// File: rtl/router_pkt_reg.sv
// Datapath register stage of the 1x3 router: header latch, FIFO write byte, stall hold and parity check.
// Define ROUTER_REG_ERR_CNT_EN to add the saturating err_count output.
module router_pkt_reg #(
  parameter int DATA_WIDTH = 8
`ifdef ROUTER_REG_ERR_CNT_EN
  , parameter int ERR_CNT_WIDTH = 8
`endif
) (
  input  logic clock,
  input  logic resetn,
  router_pkt_reg_if.slave bus
`ifdef ROUTER_REG_ERR_CNT_EN
  , output logic [ERR_CNT_WIDTH-1:0] err_count
`endif
);

  logic [DATA_WIDTH-1:0] header_q,  header_d;
  logic [DATA_WIDTH-1:0] hold_q,    hold_d;
  logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
  logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
  logic [DATA_WIDTH-1:0] dout_q,    dout_d;
  logic                  hold_is_par_q,   hold_is_par_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  parity_done_q,   parity_done_d;
  logic                  err_q,           err_d;

  logic hdr_accept;
  logic ld_accept;
  logic ld_stall;
  logic par_from_ld;
  logic par_from_laf;
  logic hold_is_payload;

  assign hdr_accept      = bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);
  assign ld_accept       = bus.ld_state && !bus.fifo_full;
  assign ld_stall        = bus.ld_state &&  bus.fifo_full;
  assign par_from_ld     = ld_accept && !bus.pkt_valid;
  // Once parity_done is set, a later load-after-full must not touch parity state again.
  assign par_from_laf    = bus.laf_state &&  hold_is_par_q && !parity_done_q;
  assign hold_is_payload = bus.laf_state && !hold_is_par_q && !parity_done_q;

  always_comb begin
    header_d = header_q;
    if (hdr_accept) begin
      header_d = bus.data_in;
    end
  end

  always_comb begin
    dout_d        = dout_q;
    hold_d        = hold_q;
    hold_is_par_d = hold_is_par_q;
    if (bus.lfd_state) begin
      dout_d = header_q;
    end else if (ld_accept) begin
      dout_d = bus.data_in;
    end else if (ld_stall) begin
      hold_d        = bus.data_in;
      hold_is_par_d = !bus.pkt_valid;
    end else if (bus.laf_state) begin
      dout_d = hold_q;
    end else if (bus.full_state) begin
      dout_d = dout_q;
    end
  end

  always_comb begin
    int_par_d = int_par_q;
    if (bus.detect_add) begin
      int_par_d = '0;
    end else if (bus.lfd_state) begin
      int_par_d = int_par_q ^ header_q;
    end else if (ld_accept && bus.pkt_valid) begin
      int_par_d = int_par_q ^ bus.data_in;
    end else if (hold_is_payload) begin
      int_par_d = int_par_q ^ hold_q;
    end
  end

  always_comb begin
    pkt_par_d     = pkt_par_q;
    parity_done_d = parity_done_q;
    if (par_from_ld) begin
      pkt_par_d = bus.data_in;
    end else if (par_from_laf) begin
      pkt_par_d = hold_q;
    end
    if (bus.detect_add) begin
      parity_done_d = 1'b0;
    end else if (par_from_ld || par_from_laf) begin
      parity_done_d = 1'b1;
    end
  end

  // low_pkt_valid records the parity byte even when it arrives during a stall.
  always_comb begin
    low_pkt_valid_d = low_pkt_valid_q;
    if (bus.rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (bus.ld_state && !bus.pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (bus.detect_add) begin
      err_d = 1'b0;
    end else if (parity_done_q) begin
      err_d = (int_par_q != pkt_par_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_q        <= '0;
      hold_q          <= '0;
      hold_is_par_q   <= 1'b0;
      int_par_q       <= '0;
      pkt_par_q       <= '0;
      dout_q          <= '0;
      low_pkt_valid_q <= 1'b0;
      parity_done_q   <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      header_q        <= header_d;
      hold_q          <= hold_d;
      hold_is_par_q   <= hold_is_par_d;
      int_par_q       <= int_par_d;
      pkt_par_q       <= pkt_par_d;
      dout_q          <= dout_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      parity_done_q   <= parity_done_d;
      err_q           <= err_d;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.err           = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [ERR_CNT_WIDTH-1:0] err_count_q;

  // Counts rising edges of err, so a packet stays counted once however long err holds.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      err_count_q <= '0;
    end else if (err_d && !err_q && (err_count_q != '1)) begin
      err_count_q <= err_count_q + CNT_ONE;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule
